input_port_rc: RTL and testbench
================================

Name: input_port_rc

Overview:
- One per router input port (N, S, E, W, L). Sits directly upstream of the 5-port switch-allocation controller.
- Buffers incoming packets in a small FIFO and computes the XY route of each packet as it is enqueued.
- Presents the head packet's 8-bit destination address and a one-hot output-port request to the allocator.
- Dequeues the head on grant and drives the buffer-full back-pressure to the upstream neighbour.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, 32, payload width per packet.
- CUR_X, 0, this router's X coordinate (4 bits).
- CUR_Y, 0, this router's Y coordinate (4 bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- in_valid  in  1  upstream offers a packet this cycle.
- in_addr  in  8  destination address: [7:4] = X, [3:0] = Y.
- in_data  in  DATA_W  packet payload.
- buffer_full_out  out  1  back-pressure to the upstream neighbour.
- packet_addr  out  8  head packet destination address.
- head_data  out  DATA_W  head packet payload.
- request  out  5  one-hot route request for the head packet. Bit order: [0] N, [1] S, [2] E, [3] W, [4] L.
- request_v  out  1  head packet valid (FIFO not empty).
- grant_i  in  1  allocator granted the head packet; dequeue it.
- overflow  out  1  sticky error flag: a push was dropped.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Read pointer, write pointer, count and overflow all go to 0.
  - request_v = 0, request = 0, buffer_full_out = 0.
  - packet_addr and head_data = 0.
  - FIFO storage is not reset.
  - Reset asserted mid-operation discards all queued packets.
- Route compute happens at enqueue time. It is combinational on in_addr, and the 3-bit encoded direction is stored alongside each entry. Rules, evaluated in order:
  - dest X > CUR_X → E; dest X < CUR_X → W.
  - Otherwise, dest Y > CUR_Y → N; dest Y < CUR_Y → S.
  - Otherwise → L.
  - All comparisons are unsigned, 4 bits.
- Head outputs:
  - packet_addr, head_data and request decode combinationally from the entry at the read pointer.
  - request is gated to 0 when the FIFO is empty.
  - request_v = (count != 0).
- Push: accepted when in_valid = 1 and either count < DEPTH, or count == DEPTH and grant_i = 1 with request_v = 1 in the same cycle.
- Dropped push: a push while full without a simultaneous pop is dropped and sets overflow = 1. overflow stays set until reset.
- Pop: occurs when grant_i = 1 and request_v = 1. grant_i while empty is ignored, with no pointer movement.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Latency: a packet written at edge t is visible on the head outputs after edge t, provided it is the only entry. Enqueue-to-request_v is therefore 1 cycle.
- Pointers wrap modulo DEPTH. Count saturates at DEPTH and is never negative.
- buffer_full_out is registered. It equals 1 when the next-state count == DEPTH, so it rises in the same cycle count reaches DEPTH.
- FIFO ordering is strict FIFO. No head-of-line bypass.

Optional Feature:
- Macro: INPUT_PORT_RC_BYPASS_EN.
- When defined: if the FIFO is empty and in_valid = 1, the incoming packet is presented on the head outputs in the same cycle (combinational bypass), with request_v = 1.
  - If grant_i = 1 in that same cycle, the packet is consumed without being written; count stays 0.
  - If grant_i = 0, the packet is written normally.
- When not defined: 1-cycle enqueue latency as described above, with no combinational path from in_* to request / request_v.

Decomposition:
- Shared package noc_pkg:
  - Direction enum dir_e {DIR_N, DIR_S, DIR_E, DIR_W, DIR_L} (3 bits).
  - COORD_W = 4 and ADDR_W = 8.
  - Helper function dir_to_onehot returning 5 bits.
  - These are shared with the controller and arbiters.
- Sub-module xy_route_compute: purely combinational; takes in_addr and CUR_X/CUR_Y and produces dir_e. It is reusable by the local injection port.

Test Plan:
1. Routing: CUR_X = 2, CUR_Y = 2. Push addr 0x52 → request = 5'b00100 (E). Push 0x12 → 5'b01000 (W). Push 0x25 → 5'b00001 (N). Push 0x20 → 5'b00010 (S). Push 0x22 → 5'b10000 (L). Granting each in turn returns them in push order.
2. Fill and back-pressure: DEPTH = 4, 4 pushes with no grant → buffer_full_out = 1 and count = 4. A 5th push without grant → dropped, overflow = 1, and the head is still packet #1.
3. Full with simultaneous push and grant: count stays 4, packet #1 leaves, the new packet enters at the tail, and overflow stays 0.
4. Empty grant: grant_i = 1 with the FIFO empty → no change; count = 0, request_v = 0.
5. Pointer wrap: 10 push/pop pairs with payloads 0..9 → payloads emerge in order 0..9, with count never exceeding 1.
6. Reset mid-stream: with 3 queued, drop rst to 0 asynchronously between edges → request_v = 0 and count = 0 immediately, and buffer_full_out = 0. After rst returns to 1, the FIFO is empty.

Source files
------------

// File: rtl/noc_pkg.sv
// ============================================================================
// Module : noc_pkg
// Brief  : Shared NoC types: route directions, address geometry, one-hot helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_pkg;
  localparam int COORD_W = 4;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_E = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  // Request bit order: [0] N, [1] S, [2] E, [3] W, [4] L
  function automatic logic [4:0] dir_to_onehot(input dir_e d);
    logic [4:0] oh;
    oh = '0;
    case (d)
      DIR_N:   oh = 5'b00001;
      DIR_S:   oh = 5'b00010;
      DIR_E:   oh = 5'b00100;
      DIR_W:   oh = 5'b01000;
      DIR_L:   oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction
endpackage

`default_nettype wire

// File: rtl/xy_route_compute.sv
// ============================================================================
// Module : xy_route_compute
// Brief  : Combinational dimension-ordered (X then Y) route selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xy_route_compute
  import noc_pkg::*;
#(
  parameter int CUR_X = 0,
  parameter int CUR_Y = 0
) (
  input  logic [ADDR_W-1:0] in_addr,
  output dir_e              route_dir
);
  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;

  assign dest_x = in_addr[ADDR_W-1 -: COORD_W];
  assign dest_y = in_addr[COORD_W-1:0];

  always_comb begin
    route_dir = DIR_L;
    if (dest_x > CX)      route_dir = DIR_E;
    else if (dest_x < CX) route_dir = DIR_W;
    else if (dest_y > CY) route_dir = DIR_N;
    else if (dest_y < CY) route_dir = DIR_S;
  end
endmodule

`default_nettype wire

// File: rtl/input_port_rc.sv
// ============================================================================
// Module : input_port_rc
// Brief  : Router input port: packet FIFO with enqueue-time XY route compute.
//          Define INPUT_PORT_RC_BYPASS_EN for same-cycle empty-FIFO bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_port_rc
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     buffer_full_out,
  output logic [ADDR_W-1:0]        packet_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [4:0]               request,
  output logic                     request_v,
  input  logic                     grant_i,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    dir_e              dir;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full_q, full_d;

  dir_e   in_dir;
  entry_t in_entry;
  entry_t head_entry;
  entry_t head_sel;
  logic   empty, fifo_full, head_valid, push, pop_fifo;

  xy_route_compute #(
    .CUR_X (CUR_X),
    .CUR_Y (CUR_Y)
  ) u_route (
    .in_addr   (in_addr),
    .route_dir (in_dir)
  );

  assign in_entry   = '{addr: in_addr, data: in_data, dir: in_dir};
  assign head_entry = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

`ifdef INPUT_PORT_RC_BYPASS_EN
  // Empty FIFO: the arriving packet is the head; a same-cycle grant consumes it unwritten.
  logic bypass;
  assign bypass     = empty && in_valid;
  assign head_sel   = bypass ? in_entry : head_entry;
  assign head_valid = !empty || in_valid;
  assign pop_fifo   = !empty && grant_i;
  assign push       = in_valid && !(bypass && grant_i) && (!fifo_full || pop_fifo);
`else
  assign head_sel   = head_entry;
  assign head_valid = !empty;
  assign pop_fifo   = !empty && grant_i;
  assign push       = in_valid && (!fifo_full || pop_fifo);
`endif

  // Storage is unreset, so head fields are gated to keep outputs clean when empty.
  assign request_v       = head_valid;
  assign packet_addr     = head_valid ? head_sel.addr : '0;
  assign head_data       = head_valid ? head_sel.data : '0;
  assign request         = head_valid ? dir_to_onehot(head_sel.dir) : 5'b00000;
  assign buffer_full_out = full_q;
  assign overflow        = overflow_q;
  assign count           = count_q;

  always_comb begin
    rd_ptr_d   = pop_fifo ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d   = push     ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    overflow_d = overflow_q || (in_valid && fifo_full && !pop_fifo);
    case ({push, pop_fifo})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end
endmodule

`default_nettype wire

// File: tb/tb_input_port_rc.sv
// ============================================================================
// Module : tb_input_port_rc
// Brief  : Scoreboard bench for input_port_rc at router (2,2), DEPTH 4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_input_port_rc;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic        buffer_full_out;
  logic [7:0]  packet_addr;
  logic [31:0] head_data;
  logic [4:0]  request;
  logic        request_v;
  logic        grant_i;
  logic        overflow;
  logic [2:0]  count;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [4:0]  req;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  input_port_rc #(
    .DEPTH  (4),
    .DATA_W (32),
    .CUR_X  (2),
    .CUR_Y  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .buffer_full_out (buffer_full_out),
    .packet_addr     (packet_addr),
    .head_data       (head_data),
    .request         (request),
    .request_v       (request_v),
    .grant_i         (grant_i),
    .overflow        (overflow),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected entry queued only when the bench knows the push is accepted.
  task automatic drive(input logic v, input logic [7:0] a, input logic [31:0] d,
                       input logic g, input logic acc, input logic [4:0] req);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    grant_i  = g;
    if (acc) exp_q.push_back('{addr: a, data: d, req: req});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_addr  = 8'h00;
    in_data  = 32'h0;
    grant_i  = 1'b0;
  endtask

  // Monitor: a granted, valid head is the packet that leaves at the next edge.
  always @(negedge clk) begin
    if (rst && grant_i && request_v) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got addr 0x%0h, expected no packet", packet_addr);
      end else begin
        e = exp_q.pop_front();
        check("pop_addr", 32'(packet_addr), 32'(e.addr));
        check("pop_data", head_data, e.data);
        check("pop_req", 32'(request), 32'(e.req));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = 8'h00; in_data = 32'h0; grant_i = 1'b0;
    #1 rst = 1'b0;
    #11;
    check("rst_request_v", 32'(request_v), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(buffer_full_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_request", 32'(request), 0);
    check("rst_addr", 32'(packet_addr), 0);
    check("rst_data", head_data, 0);
    rst = 1'b1;

    // Routing at (2,2), plus push+grant while full
    drive(1, 8'h52, 32'd100, 0, 1, 5'b00100);
    check("lat_request_v", 32'(request_v), 1);
    check("lat_request_e", 32'(request), 32'b00100);
    check("lat_count", 32'(count), 1);
    drive(1, 8'h12, 32'd101, 0, 1, 5'b01000);
    drive(1, 8'h25, 32'd102, 0, 1, 5'b00001);
    drive(1, 8'h20, 32'd103, 0, 1, 5'b00010);
    check("fill_count", 32'(count), 4);
    check("fill_full", 32'(buffer_full_out), 1);
    drive(1, 8'h22, 32'd104, 1, 1, 5'b10000);
    check("pushpop_count", 32'(count), 4);
    check("pushpop_overflow", 32'(overflow), 0);
    check("pushpop_full", 32'(buffer_full_out), 1);
    check("pushpop_head", 32'(packet_addr), 32'h12);
    drive(0, 8'h00, 32'd0, 1, 0, 5'b0);
    check("unfull_count", 32'(count), 3);
    check("unfull_full", 32'(buffer_full_out), 0);
    repeat (3) drive(0, 8'h00, 32'd0, 1, 0, 5'b0);
    check("drain_count", 32'(count), 0);
    check("drain_request", 32'(request), 0);

    // Grant on empty FIFO
    drive(0, 8'h00, 32'd0, 1, 0, 5'b0);
    check("empty_grant_count", 32'(count), 0);
    check("empty_grant_v", 32'(request_v), 0);
    check("empty_grant_ovf", 32'(overflow), 0);

    // Fill and drop
    for (int i = 0; i < 4; i++) drive(1, 8'h22, 32'd200 + 32'(i), 0, 1, 5'b10000);
    check("bp_full", 32'(buffer_full_out), 1);
    drive(1, 8'h52, 32'd204, 0, 0, 5'b0);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_count", 32'(count), 4);
    check("drop_head_data", head_data, 32'd200);
    repeat (4) drive(0, 8'h00, 32'd0, 1, 0, 5'b0);
    check("ovf_sticky", 32'(overflow), 1);

    // Pointer wrap with single-entry occupancy
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'h32, 32'(i), 0, 1, 5'b00100);
      check("wrap_count_le1", 32'(count <= 3'd1), 1);
      drive(0, 8'h00, 32'd0, 1, 0, 5'b0);
      check("wrap_count_zero", 32'(count), 0);
    end

    // Asynchronous reset with packets queued
    for (int i = 0; i < 3; i++) drive(1, 8'h52, 32'd300 + 32'(i), 0, 0, 5'b0);
    check("pre_rst_count", 32'(count), 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_v", 32'(request_v), 0);
    check("async_rst_count", 32'(count), 0);
    check("async_rst_full", 32'(buffer_full_out), 0);
    check("async_rst_ovf", 32'(overflow), 0);
    #1 rst = 1'b1;
    drive(0, 8'h00, 32'd0, 0, 0, 5'b0);
    check("post_rst_v", 32'(request_v), 0);
    check("post_rst_count", 32'(count), 0);
    drive(1, 8'h21, 32'd400, 0, 1, 5'b00010);
    drive(0, 8'h00, 32'd0, 1, 0, 5'b0);
    check("post_rst_drain", 32'(count), 0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
